// File: rtl/uart_mmio.sv
// Small generic FIFO used for the UART receive queue.
// Latency: push visible at head/count the cycle after the push edge.
// Backpressure: push_rdy drops when full unless a pop happens in the same cycle.
module uart_mmio_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    output logic                       push_rdy,
    input  logic                       pop_vld,
    output logic [W-1:0]               head_dat,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    // A full FIFO is never empty, so a requested pop always frees a slot.
    assign push_rdy = (count != CNT_FULL) || pop_vld;
    assign do_pop   = pop_vld && !empty;
    assign do_push  = push_vld && push_rdy;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Memory-mapped 8N1 UART: TXD/RXD/CON registers on the MEM-stage data bus.
// Latency: rdata/hit combinational; TX line low the cycle after an accepted store.
// Backpressure: stores to TXD while busy are dropped (tx_overrun); RX drops on full FIFO (rx_overflow).
module uart_mmio #(
    parameter int CLKS_PER_BIT = 434,
    parameter int RX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int FC_W = $clog2(RX_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic sel_txd, sel_rxd, sel_con;
    logic txd_wr, con_wr, rxd_rd;

    logic [1:0]       tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic [7:0]       tx_byte;
    logic             tx_busy;
    logic             tx_done_set;
    logic             tx_overrun_set;

    logic             rx_meta, rxs;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_stop_done;
    logic             rx_push_vld;
    logic             rx_push_rdy;
    logic             rx_overflow_set;
    logic             frame_err_set;

    logic [7:0]       rx_head;
    logic             rx_empty;
    logic             rx_nonempty;
    logic [FC_W-1:0]  rx_count;
    logic [3:0]       rx_count4;

    logic tx_irq_en, rx_irq_en;
    logic tx_done, rx_overflow, tx_overrun, frame_err;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    assign sel_txd = (addr == ADDR_TXD);
    assign sel_rxd = (addr == ADDR_RXD);
    assign sel_con = (addr == ADDR_CON);
    assign hit     = sel_txd | sel_rxd | sel_con;
    assign txd_wr  = mem_write & sel_txd;
    assign con_wr  = mem_write & sel_con;
    assign rxd_rd  = mem_read & sel_rxd;

    assign tx_busy        = (tx_state != ST_IDLE);
    assign tx_done_set    = (tx_state == ST_STOP) && (tx_cnt == BIT_LAST);
    assign tx_overrun_set = txd_wr && tx_busy;

    // uart_tx is loaded with the level of the bit being entered, so it stays registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_byte  <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (txd_wr) begin
                        tx_byte  <= wdata[7:0];
                        tx_shift <= wdata[7:0];
                        tx_cnt   <= '0;
                        uart_tx  <= 1'b0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            uart_tx  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_stop_done    = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST);
    assign rx_push_vld     = rx_stop_done && rxs;
    assign frame_err_set   = rx_stop_done && !rxs;
    assign rx_overflow_set = rx_push_vld && !rx_push_rdy;

    // Start is re-checked half a bit in, so later samples land mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
            case (rx_state)
                ST_IDLE: begin
                    if (!rxs) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    uart_mmio_fifo #(
        .W     (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rx_push_vld),
        .push_dat (rx_shift),
        .push_rdy (rx_push_rdy),
        .pop_vld  (rxd_rd),
        .head_dat (rx_head),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    assign rx_nonempty = !rx_empty;
    assign rx_count4   = 4'(rx_count);

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_irq_en   <= 1'b0;
            rx_irq_en   <= 1'b0;
            tx_done     <= 1'b0;
            rx_overflow <= 1'b0;
            tx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (con_wr) begin
                tx_irq_en <= wdata[0];
                rx_irq_en <= wdata[1];
            end
            tx_done     <= (tx_done     & ~(con_wr & wdata[2])) | tx_done_set;
            rx_overflow <= (rx_overflow & ~(con_wr & wdata[5])) | rx_overflow_set;
            tx_overrun  <= (tx_overrun  & ~(con_wr & wdata[6])) | tx_overrun_set;
            frame_err   <= (frame_err   & ~(con_wr & wdata[7])) | frame_err_set;
            irq         <= (tx_irq_en & tx_done) | (rx_irq_en & rx_nonempty);
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_txd) begin
            rdata = {24'b0, tx_byte};
        end else if (sel_rxd) begin
            rdata = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_head};
        end else if (sel_con) begin
            rdata = {20'b0, rx_count4, frame_err, tx_overrun, rx_overflow,
                     tx_busy, rx_nonempty, tx_done, rx_irq_en, tx_irq_en};
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: register table, TX frame monitor, RX scoreboard, corner sequences.
`timescale 1ns/1ps
module tb_uart_mmio;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam int NV = 14;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [31:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] rdata;
    logic        hit;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic exp_ovf = 1'b0;
    logic exp_ferr = 1'b0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    uart_mmio #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata), .hit(hit),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mem_write = 1'b1;
        cyc();
        mem_write = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
        addr = '0;
    endtask

    task automatic rx_read(input string name);
        logic [31:0] exp;
        exp = (rx_q.size() > 0) ? {23'b0, 1'b1, rx_q.pop_front()} : 32'h0;
        addr = A_RXD; mem_read = 1'b1;
        #1;
        chk(name, rdata, exp);
        cyc();
        mem_read = 1'b0; addr = '0;
    endtask

    // Drives one frame starting in the current cycle; optional RXD pop lands on the push edge.
    task automatic send_rx(input logic [7:0] b, input logic stop, input logic pop_at_end);
        logic [9:0]  fr;
        logic [31:0] exp_pop;
        fr = {stop, b, 1'b0};
        exp_pop = 32'h0;
        if (pop_at_end && rx_q.size() > 0) exp_pop = {23'b0, 1'b1, rx_q.pop_front()};
        if (!stop) exp_ferr = 1'b1;
        else if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else exp_ovf = 1'b1;
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            cyc(CPB);
        end
        uart_rx = 1'b1;
        if (pop_at_end) begin
            addr = A_RXD; mem_read = 1'b1;
            #1;
            chk("rx_pop_on_push", rdata, exp_pop);
            cyc();
            mem_read = 1'b0; addr = '0;
            cyc(3);
        end else begin
            cyc(4);
        end
    endtask

    task automatic wait_tx_done(input string name);
        logic [31:0] v;
        logic        done;
        done = 1'b0;
        for (int i = 0; i < 20 * CPB && !done; i++) begin
            peek(A_CON, v);
            if (v[2]) done = 1'b1;
            else cyc();
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // TX monitor: every bit must hold its level for all CPB cycles.
    initial begin : tx_mon
        logic [9:0] fr;
        logic [7:0] b;
        logic       aborted;
        logic       mism;
        logic       bad_lvl;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                aborted = 1'b0;
                if (tx_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected_frame: start bit seen with no byte queued");
                    b = 8'h00;
                end else begin
                    b = tx_q.pop_front();
                end
                fr = {1'b1, b, 1'b0};
                for (int bi = 0; bi < 10 && !aborted; bi++) begin
                    mism = 1'b0;
                    bad_lvl = fr[bi];
                    for (int k = 0; k < CPB && !aborted; k++) begin
                        if (!(bi == 0 && k == 0)) @(negedge clk);
                        if (!rst_n) aborted = 1'b1;
                        else if (uart_tx !== fr[bi]) begin
                            mism = 1'b1;
                            bad_lvl = uart_tx;
                        end
                    end
                    if (!aborted) begin
                        total++;
                        if (mism) begin
                            bad++;
                            $display("FAIL tx_frame byte=%02h bit=%0d: line=%b want=%b", b, bi, bad_lvl, fr[bi]);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] v;
        vecs[0]  = '{A_TXD,        32'h0,  1'b1, 1'b0, 32'h0, 1'b1};
        vecs[1]  = '{A_RXD,        32'h0,  1'b1, 1'b0, 32'h0, 1'b1};
        vecs[2]  = '{A_CON,        32'h0,  1'b1, 1'b0, 32'h0, 1'b1};
        vecs[3]  = '{32'h0,        32'h0,  1'b0, 1'b0, 32'h0, 1'b0};
        vecs[4]  = '{32'h4000_0024, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
        vecs[5]  = '{32'h4000_0014, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{32'h4000_001A, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
        vecs[7]  = '{A_CON,        32'h3,  1'b0, 1'b1, 32'h0, 1'b1};
        vecs[8]  = '{A_CON,        32'h0,  1'b1, 1'b0, 32'h3, 1'b1};
        vecs[9]  = '{A_RXD,        32'hFF, 1'b0, 1'b1, 32'h0, 1'b1};
        vecs[10] = '{A_RXD,        32'h0,  1'b1, 1'b0, 32'h0, 1'b1};
        vecs[11] = '{A_CON,        32'hE4, 1'b0, 1'b1, 32'h3, 1'b1};
        vecs[12] = '{A_CON,        32'h0,  1'b1, 1'b0, 32'h0, 1'b1};
        vecs[13] = '{A_TXD,        32'h0,  1'b1, 1'b0, 32'h0, 1'b1};

        cyc(3);
        rst_n = 1'b1;
        cyc();
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);

        for (int i = 0; i < NV; i++) begin
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            mem_read = vecs[i].rd; mem_write = vecs[i].wr;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
            cyc();
        end
        mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        chk("table_irq", 32'(irq), 32'd0);

        // TX frame 0xA5 with tx interrupt
        bus_wr(A_CON, 32'h1);
        tx_q.push_back(8'hA5);
        bus_wr(A_TXD, 32'hA5);
        chk("tx_start_low", 32'(uart_tx), 32'd0);
        peek(A_CON, v); chk("tx_busy_set", 32'(v[4]), 32'd1);
        cyc(39);
        peek(A_CON, v); chk("tx_done_early", 32'(v[2]), 32'd0);
        cyc();
        peek(A_CON, v); chk("tx_done_set", 32'(v[2]), 32'd1);
        chk("tx_busy_clr", 32'(v[4]), 32'd0);
        chk("irq_lag", 32'(irq), 32'd0);
        cyc();
        chk("irq_tx", 32'(irq), 32'd1);
        bus_wr(A_CON, 32'h5);
        cyc();
        chk("irq_tx_clr", 32'(irq), 32'd0);
        peek(A_CON, v); chk("con_after_clr", v, 32'h1);

        // write while busy is dropped
        bus_wr(A_CON, 32'h0);
        tx_q.push_back(8'h11);
        bus_wr(A_TXD, 32'h11);
        cyc(10);
        bus_wr(A_TXD, 32'h22);
        peek(A_TXD, v); chk("txd_readback", v, 32'h11);
        wait_tx_done("ovr_frame_done");
        peek(A_CON, v); chk("con_overrun", v, 32'h44);
        bus_wr(A_CON, 32'hC4);
        peek(A_CON, v); chk("con_overrun_clr", v, 32'h0);
        cyc(50);
        chk("tx_q_drained", 32'(tx_q.size()), 32'd0);

        // two RX frames with rx interrupt
        bus_wr(A_CON, 32'h2);
        send_rx(8'h3C, 1'b1, 1'b0);
        send_rx(8'h81, 1'b1, 1'b0);
        peek(A_CON, v); chk("rx_count2", 32'(v[11:8]), 32'(rx_q.size()));
        chk("irq_rx", 32'(irq), 32'd1);
        rx_read("rxd_read0");
        rx_read("rxd_read1");
        rx_read("rxd_read_empty");
        cyc();
        chk("irq_rx_clr", 32'(irq), 32'd0);

        // overflow, then push while full with a simultaneous pop
        bus_wr(A_CON, 32'h0);
        for (int i = 0; i < 5; i++) send_rx(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        peek(A_CON, v);
        chk("ovf_count", 32'(v[11:8]), 32'(rx_q.size()));
        chk("ovf_flag", 32'(v[5]), 32'(exp_ovf));
        bus_wr(A_CON, 32'h20); exp_ovf = 1'b0;
        peek(A_CON, v); chk("ovf_clr", 32'(v[5]), 32'd0);
        send_rx(8'h5A, 1'b1, 1'b1);
        peek(A_CON, v);
        chk("full_pushpop_count", 32'(v[11:8]), 32'(rx_q.size()));
        chk("full_pushpop_noovf", 32'(v[5]), 32'(exp_ovf));
        for (int i = 0; i < 5; i++) rx_read($sformatf("drain%0d", i));

        // framing error and idle glitch
        send_rx(8'h77, 1'b0, 1'b0);
        peek(A_CON, v);
        chk("ferr_flag", 32'(v[7]), 32'(exp_ferr));
        chk("ferr_count", 32'(v[11:8]), 32'(rx_q.size()));
        bus_wr(A_CON, 32'h80); exp_ferr = 1'b0;
        uart_rx = 1'b0;
        cyc();
        uart_rx = 1'b1;
        cyc(20);
        peek(A_CON, v); chk("glitch_con", v, 32'h0);
        rx_read("glitch_rxd");

        // reset in the middle of a TX frame and a partial RX frame
        uart_rx = 1'b0;
        tx_q.push_back(8'h00);
        bus_wr(A_TXD, 32'h00);
        cyc(12);
        #2;
        rst_n = 1'b0;
        uart_rx = 1'b1;
        #1;
        chk("rst_mid_tx_high", 32'(uart_tx), 32'd1);
        cyc(2);
        rst_n = 1'b1;
        tx_q.delete();
        rx_q.delete();
        cyc(2);
        peek(A_CON, v); chk("rst_mid_con", v, 32'h0);
        peek(A_TXD, v); chk("rst_mid_txd", v, 32'h0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        send_rx(8'hA5, 1'b1, 1'b0);
        rx_read("post_rst_rx");

        cyc(5);
        chk("end_tx_q", 32'(tx_q.size()), 32'd0);
        chk("end_rx_q", 32'(rx_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral that sits on the data-memory bus beside the MEM stage of the pipelined CPU. It decodes three word addresses, turns a store into an 8N1 serial frame, and deserialises incoming frames into a small RX FIFO that loads can drain. It raises a level interrupt toward the CPU's IRQ input on TX completion or RX data available.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (434 gives 115200 baud at 50 MHz); must be ≥ 4.
- RX_DEPTH, 4, RX FIFO entries; must be a power of two, ≤ 8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- addr  input  32  byte address of the current MEM-stage access (ALU result).
- wdata  input  32  store data (rt value).
- mem_read  input  1  load in MEM stage this cycle.
- mem_write  input  1  store in MEM stage this cycle.
- rdata  output  32  read data; combinational; 0 when no register is addressed.
- hit  output  1  combinational; addr equals one of the three register addresses.
- uart_rx  input  1  asynchronous serial input; idle high.
- uart_tx  output  1  serial output; registered; idle high.
- irq  output  1  registered level interrupt.

## Operation
Registers (exact word-address match; other addresses give hit=0):
- 0x40000018 TXD. A write loads wdata[7:0] and starts a frame if TX is idle. A write while busy is ignored and sets tx_overrun. A read returns {24'b0, last accepted byte}.
- 0x4000001C RXD. A read returns {23'b0, valid, head byte}, where valid = FIFO not empty. A read with mem_read=1 and a non-empty FIFO pops one entry at the clock edge. A read while empty returns 0 and pops nothing. Writes are ignored.
- 0x40000020 CON. Read layout:
  - bit0 tx_irq_en, bit1 rx_irq_en
  - bit2 tx_done (sticky), bit3 rx_nonempty, bit4 tx_busy
  - bit5 rx_overflow (sticky), bit6 tx_overrun (sticky), bit7 frame_err (sticky)
  - bits[11:8] FIFO count; other bits 0.
- CON write: wdata[1:0] loads the enables. Writing 1 to bit 2, 5, 6 or 7 clears that sticky flag (write-1-to-clear).
- Interrupt: irq <= (tx_irq_en & tx_done) | (rx_irq_en & rx_nonempty).

TX FSM (IDLE, START, DATA, STOP):
- Frame is a start bit (0), 8 data bits LSB first, then a stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
- tx_busy=1 in every state except IDLE.
- When STOP ends: tx_done is set and the FSM returns to IDLE.

RX FSM (IDLE, START, DATA, STOP):
- uart_rx passes through a 2-flop synchroniser; the FSM uses the synchronised value rxs.
- IDLE: rxs=0 moves to START.
- START: after CLKS_PER_BIT/2 cycles, if rxs=0 go to DATA, else treat as a glitch and return to IDLE.
- DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
- STOP: after CLKS_PER_BIT cycles, sample the stop bit.
  - Stop=1: push the byte. If the FIFO is full and no pop occurs that cycle, drop the byte and set rx_overflow.
  - Stop=0: discard the byte and set frame_err.
  - Either way, return to IDLE.

FIFO rules:
- Pointers wrap modulo RX_DEPTH; count spans 0..RX_DEPTH.
- Push and pop in the same cycle: both take effect and count is unchanged. This also applies when full: the pushed byte is accepted.

Simultaneous-event rules:
- A CON clear and a set of the same flag in the same cycle: the set wins.
- Reset mid-frame: both FSMs return to IDLE and uart_tx is forced to 1 immediately; a partial RX byte is lost.

## Timing
- Reset values: uart_tx=1, irq=0, all flags and enables 0, FIFO empty, TXD byte 0. With no access, rdata=0 and hit=0.
- rdata/hit: same cycle as addr, with no register stage, so MEM can capture it into MEM/WB.
- TX write accepted at edge N: uart_tx=0 from N+1, and tx_busy reads 1 from N+1. The frame lasts 10·CLKS_PER_BIT cycles, and tx_done is visible the cycle after the last stop-bit cycle.
- irq follows its condition by 1 cycle, and deasserts 1 cycle after a clear or pop removes the cause.
- RX push latency: 2 synchroniser cycles, plus about 9.5·CLKS_PER_BIT cycles from the falling start edge.

## Test plan
Benches run with CLKS_PER_BIT=4 and RX_DEPTH=4.
1. Reset, then read all three registers -> rdata=0 each; uart_tx=1; irq=0.
2. CON←0x1, then TXD←0xA5 -> uart_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_done sets after 40 cycles and irq=1 one cycle later. CON←0x5 -> irq=0 the next cycle.
3. TXD←0x11, then TXD←0x22 during the frame -> the frame carries 0x11 only; CON bit6=1.
4. Drive RX frames 0x3C then 0x81 -> CON[11:8]=2. Successive RXD reads return 0x13C, 0x181, then 0x000.
5. Five RX frames with no reads -> count=4 and rx_overflow=1. Four reads return the first four bytes in order.
6. A frame with stop bit 0 -> not pushed, frame_err=1. A 1-cycle low glitch while idle -> no push, no flag.
